// File: rtl/i2s_frame_scheduler.sv
// Stereo frame scheduler: pairs buffered left/right samples into ws-tagged words
// for an I2S serializer, substituting FILL_WORD and counting underruns when a channel is empty.
module i2s_frame_scheduler #(
  parameter int                DATA_W    = 8,
  parameter int                CNT_W     = 8,
  parameter logic [DATA_W-1:0] FILL_WORD = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              l_valid,
  output logic              l_ready,
  input  logic [DATA_W-1:0] l_data,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [DATA_W-1:0] r_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_ws,
  output logic [DATA_W-1:0] tx_data,
  input  logic              underrun_clr,
  output logic [CNT_W-1:0]  underrun_count,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LEFT  = 2'd1,
    S_RIGHT = 2'd2
  } state_t;

  state_t            state, state_next;
  logic              l_full, r_full;
  logic [DATA_W-1:0] l_buf, r_buf;
  logic              slot_free;
  logic              load, load_ws;
  logic [DATA_W-1:0] load_data;
  logic              l_take, r_take, underrun;

  assign l_ready   = ~l_full;
  assign r_ready   = ~r_full;
  assign slot_free = ~tx_valid | tx_ready;
  assign busy      = (state != S_IDLE) | tx_valid;

  // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
  always_comb begin
    state_next = state;
    load       = 1'b0;
    load_ws    = 1'b0;
    load_data  = FILL_WORD;
    l_take     = 1'b0;
    r_take     = 1'b0;
    underrun   = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable && l_full) state_next = S_LEFT;
      end
      S_LEFT: begin
        if (slot_free) begin
          load    = 1'b1;
          load_ws = 1'b0;
          if (l_full) begin
            load_data = l_buf;
            l_take    = 1'b1;
          end else begin
            underrun = 1'b1;
          end
          state_next = S_RIGHT;
        end
      end
      S_RIGHT: begin
        // A started frame always finishes with its right word, even if enable drops.
        if (slot_free) begin
          load    = 1'b1;
          load_ws = 1'b1;
          if (r_full) begin
            load_data = r_buf;
            r_take    = 1'b1;
          end else begin
            underrun = 1'b1;
          end
          state_next = enable ? S_LEFT : S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // A buffer only accepts while empty and is only consumed while full, so load and take never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_full <= 1'b0;
      r_full <= 1'b0;
    end else begin
      if (l_valid && l_ready) l_full <= 1'b1;
      else if (l_take)        l_full <= 1'b0;
      if (r_valid && r_ready) r_full <= 1'b1;
      else if (r_take)        r_full <= 1'b0;
    end
  end

  // NOTE: sample storage has no reset; its contents are only ever read while the matching full flag is set.
  always_ff @(posedge clk) begin
    if (l_valid && l_ready) l_buf <= l_data;
    if (r_valid && r_ready) r_buf <= r_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_valid <= 1'b0;
      tx_ws    <= 1'b0;
      tx_data  <= '0;
    end else if (load) begin
      tx_valid <= 1'b1;
      tx_ws    <= load_ws;
      tx_data  <= load_data;
    end else if (slot_free) begin
      tx_valid <= 1'b0;
    end
  end

  // Clear takes priority over a same-cycle underrun; the count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     underrun_count <= '0;
    else if (underrun_clr)                       underrun_count <= '0;
    else if (underrun && (underrun_count != '1)) underrun_count <= underrun_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_i2s_frame_scheduler.sv
// Self-checking bench for i2s_frame_scheduler: scoreboard of expected tx words,
// a table of single-frame vectors, and hand sequences for stalls, clear, and reset.
module tb_i2s_frame_scheduler;

  localparam int          DATA_W = 8;
  localparam int          CNT_W  = 2;
  localparam logic [7:0]  FILL   = 8'hEE;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic              l_valid, l_ready;
  logic [DATA_W-1:0] l_data;
  logic              r_valid, r_ready;
  logic [DATA_W-1:0] r_data;
  logic              tx_valid, tx_ready, tx_ws;
  logic [DATA_W-1:0] tx_data;
  logic              underrun_clr;
  logic [CNT_W-1:0]  underrun_count;
  logic              busy;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;
  logic [8:0] expq[$];

  i2s_frame_scheduler #(.DATA_W(DATA_W), .CNT_W(CNT_W), .FILL_WORD(FILL)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .l_valid(l_valid), .l_ready(l_ready), .l_data(l_data),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_ws(tx_ws), .tx_data(tx_data),
    .underrun_clr(underrun_clr), .underrun_count(underrun_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs are only changed 1 time unit after a rising edge, so at the falling
  // edge tx_valid & tx_ready tells exactly whether the next edge is a handshake.
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      if (expq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL tx_unexpected: got %0h expected none", {tx_ws, tx_data});
      end else begin
        check("tx_word", {tx_ws, tx_data}, expq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic lv, input logic [7:0] ld, input logic rv, input logic [7:0] rd);
    l_valid = lv; l_data = ld;
    r_valid = rv; r_data = rd;
    tick();
    l_valid = 1'b0;
    r_valid = 1'b0;
  endtask

  task automatic bump_cnt();
    if (exp_cnt < 3) exp_cnt++;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 40; i++) begin
      if (expq.size() == 0 && !busy) break;
      tick();
    end
    check(name, {31'd0, (expq.size() == 0 && !busy)}, 32'd1);
  endtask

  typedef struct {
    logic [7:0] l_data;
    logic       r_present;
    logic [7:0] r_data;
    int         exp_cnt;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [8:0] held;

    vecs[0] = '{8'hA5, 1'b1, 8'h3C, 1};
    vecs[1] = '{8'h11, 1'b0, 8'h00, 2};
    vecs[2] = '{8'h00, 1'b1, 8'hFF, 2};
    vecs[3] = '{8'h80, 1'b0, 8'h00, 3};
    vecs[4] = '{8'h7F, 1'b1, 8'h01, 3};
    vecs[5] = '{8'h5A, 1'b0, 8'h00, 3};
    vecs[6] = '{8'hC3, 1'b0, 8'h00, 3};

    rst = 1'b1; enable = 1'b0; l_valid = 1'b0; r_valid = 1'b0;
    l_data = '0; r_data = '0; tx_ready = 1'b0; underrun_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_ws", tx_ws, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_ready", {l_ready, r_ready}, 2'b11);
    check("rst_busy", busy, 0);
    check("rst_count", underrun_count, 0);
    rst = 1'b0;
    tick();

    // Latency, stall hold, and enable dropped during a right-slot stall.
    enable = 1'b1; tx_ready = 1'b0;
    expq.push_back({1'b0, 8'h42});
    push(1'b1, 8'h42, 1'b0, 8'h00);
    tick();
    check("lat_n1_tx_valid", tx_valid, 0);
    check("lat_n1_busy", busy, 1);
    tick();
    check("lat_n2_word", {tx_valid, tx_ws, tx_data}, {2'b10, 8'h42});
    expq.push_back({1'b1, 8'h24});
    expq.push_back({1'b0, 8'h99});
    push(1'b1, 8'h99, 1'b1, 8'h24);
    check("stall_ready_low", {l_ready, r_ready}, 2'b00);
    held = {tx_ws, tx_data};
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_hold", {tx_valid, tx_ws, tx_data}, {1'b1, held});
    end
    enable = 1'b0; tx_ready = 1'b1;
    tick();
    check("right_issued", {tx_valid, tx_ws, tx_data}, {2'b11, 8'h24});
    check("right_busy", busy, 1);
    tick();
    check("busy_fall", busy, 0);
    check("l_still_held", l_ready, 0);
    expq.push_back({1'b1, FILL});
    bump_cnt();
    enable = 1'b1;
    tick();
    enable = 1'b0;
    wait_drain("seq_a_drain");
    check("seq_a_count", underrun_count, exp_cnt);

    // Table of single frames: L always present, R present or filled.
    tx_ready = 1'b1;
    for (int v = 0; v < 7; v++) begin
      expq.push_back({1'b0, vecs[v].l_data});
      if (vecs[v].r_present) begin
        expq.push_back({1'b1, vecs[v].r_data});
      end else begin
        expq.push_back({1'b1, FILL});
        bump_cnt();
      end
      push(1'b1, vecs[v].l_data, vecs[v].r_present, vecs[v].r_data);
      enable = 1'b1;
      tick();
      enable = 1'b0;
      wait_drain("vec_drain");
      check("vec_count", underrun_count, vecs[v].exp_cnt);
      check("vec_count_model", underrun_count, exp_cnt);
    end

    // Clear lands on the same edge as a right-slot underrun.
    tx_ready = 1'b0;
    expq.push_back({1'b0, 8'h10});
    expq.push_back({1'b1, FILL});
    push(1'b1, 8'h10, 1'b0, 8'h00);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    tick();
    tick();
    check("clr_pre_count", underrun_count, 3);
    tx_ready = 1'b1; underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    exp_cnt = 0;
    check("clr_wins", underrun_count, 0);
    wait_drain("clr_drain");
    check("clr_after", underrun_count, exp_cnt);

    // Continuous enable with no samples: right then left underrun on consecutive slots.
    enable = 1'b1;
    expq.push_back({1'b0, 8'h77});
    expq.push_back({1'b1, FILL});
    expq.push_back({1'b0, FILL});
    expq.push_back({1'b1, FILL});
    push(1'b1, 8'h77, 1'b0, 8'h00);
    tick();
    tick();
    tick();
    check("consec_1", underrun_count, 1);
    tick();
    check("consec_2", underrun_count, 2);
    check("consec_left_fill", {tx_ws, tx_data}, {1'b0, FILL});
    enable = 1'b0;
    tick();
    check("consec_3", underrun_count, 3);
    wait_drain("consec_drain");

    // Asynchronous reset with both buffers full and a word on offer.
    tx_ready = 1'b0; enable = 1'b1;
    expq.push_back({1'b0, 8'hAA});
    push(1'b1, 8'hAA, 1'b0, 8'h00);
    tick();
    tick();
    push(1'b1, 8'hBB, 1'b1, 8'hCC);
    check("pre_rst_state", {tx_valid, l_ready, r_ready}, 3'b100);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_tx_valid", tx_valid, 0);
    check("rst_mid_ready", {l_ready, r_ready}, 2'b11);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_count", underrun_count, 0);
    expq.delete();
    exp_cnt = 0;
    enable = 1'b0;
    #1 rst = 1'b0;
    tick();
    check("post_rst_idle", {busy, tx_valid}, 2'b00);
    tx_ready = 1'b1;
    expq.push_back({1'b0, 8'h5C});
    expq.push_back({1'b1, 8'hC5});
    push(1'b1, 8'h5C, 1'b1, 8'hC5);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    wait_drain("post_rst_drain");
    check("post_rst_count", underrun_count, exp_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
